// File: rtl/three_color_light_pkg.sv
// Shared types and helpers for the three-colour traffic-light controller:
// phase encoding, 7-segment codes and the BCD split used by the display.
package three_color_light_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_RED    = 2'd2
    } phase_e;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Returns {tens, ones}; the countdown never exceeds 99.
    function automatic logic [7:0] bcd_split(input logic [6:0] value);
        int v;
        v = int'(value);
        return {4'(v / 32'sd10), 4'(v % 32'sd10)};
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        phase_e nxt;
        case (ph)
            PH_GREEN:  nxt = PH_YELLOW;
            PH_YELLOW: nxt = PH_RED;
            PH_RED:    nxt = PH_GREEN;
            default:   nxt = PH_GREEN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/three_color_light_key_debounce.sv
// Key conditioner: two-flop synchroniser, stability filter and a single
// one-cycle pulse on each accepted rising edge of the key level.
module key_debounce #(
    parameter int DEBOUNCE = 500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic press_o
);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Accept a new level only after DEBOUNCE consecutive differing samples.
    always_comb begin
        cnt_d   = {CNT_W{1'b0}};
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                cnt_d   = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1'b1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Synchroniser, filter state and registered rising-edge pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            sync1_q     <= key_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/three_color_light_top.sv
// Three-colour traffic-light controller: phase countdown, night blink,
// manual stepping, pedestrian shortening and a two-digit 7-segment display.
module three_color_light_top
    import three_color_light_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_DIV = CLK_HZ,
    parameter int SCAN_DIV = 50_000,
    parameter int DEBOUNCE = 500_000,
    parameter int GREEN_S  = 25,
    parameter int YELLOW_S = 5,
    parameter int RED_S    = 30
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic [1:0] Key,
    input  logic [1:0] Switch,
    output logic [3:0] LED,
    output logic [7:0] SEG,
    output logic [1:0] COM
);
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [6:0] GREEN_CNT  = 7'(GREEN_S);
    localparam logic [6:0] YELLOW_CNT = 7'(YELLOW_S);
    localparam logic [6:0] RED_CNT    = 7'(RED_S);
    localparam logic [7:0] RESET_BCD  = bcd_split(GREEN_CNT);
    localparam logic [7:0] RESET_SEG  = seg_code(RESET_BCD[3:0]);

    function automatic logic [6:0] phase_dur(input phase_e ph);
        logic [6:0] dur;
        case (ph)
            PH_GREEN:  dur = GREEN_CNT;
            PH_YELLOW: dur = YELLOW_CNT;
            PH_RED:    dur = RED_CNT;
            default:   dur = GREEN_CNT;
        endcase
        return dur;
    endfunction

    phase_e            phase_q, phase_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              yel_q, yel_d;
    logic              night_q, man_q;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic              digit_q, digit_d;
    logic [3:0]        led_q, led_d;
    logic [7:0]        seg_q, seg_d;
    logic [1:0]        com_q, com_d;

    logic       adv_s;
    logic       ped_s;
    logic       tick_s;
    logic       ped_ok_s;
    logic       scan_wrap_s;
    logic [7:0] bcd_s;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_adv (
        .clk_i   (Sys_CLK),
        .rst_i   (Sys_RST),
        .key_i   (Key[0]),
        .press_o (adv_s)
    );

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_ped (
        .clk_i   (Sys_CLK),
        .rst_i   (Sys_RST),
        .key_i   (Key[1]),
        .press_o (ped_s)
    );

    assign tick_s      = (div_q == DIV_MAX);
    assign scan_wrap_s = (scan_q == SCAN_MAX);
    assign ped_ok_s    = ped_s && (phase_q == PH_GREEN) && (cnt_q > YELLOW_CNT);
    assign bcd_s       = bcd_split(cnt_q);

    // Phase/countdown next state; a key press takes precedence over a tick.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        yel_d   = yel_q;
        div_d   = tick_s ? {DIV_W{1'b0}} : div_q + DIV_W'(1'b1);
        if (Switch[0]) begin
            phase_d = PH_GREEN;
            cnt_d   = GREEN_CNT;
            if (tick_s) begin
                yel_d = ~yel_q;
            end else begin
                yel_d = yel_q;
            end
        end else if (night_q) begin
            // First cycle out of night mode: restart cleanly in green.
            phase_d = PH_GREEN;
            cnt_d   = GREEN_CNT;
            div_d   = {DIV_W{1'b0}};
            yel_d   = 1'b0;
        end else if (Switch[1]) begin
            if (adv_s) begin
                phase_d = next_phase(phase_q);
                cnt_d   = phase_dur(next_phase(phase_q));
            end else if (ped_ok_s) begin
                cnt_d = YELLOW_CNT;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            if (ped_ok_s) begin
                cnt_d = YELLOW_CNT;
            end else if (tick_s) begin
                if (cnt_q > 7'd1) begin
                    cnt_d = cnt_q - 7'd1;
                end else begin
                    phase_d = next_phase(phase_q);
                    cnt_d   = phase_dur(next_phase(phase_q));
                end
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Digit scan: flip between ones and tens every SCAN_DIV cycles.
    always_comb begin
        scan_d  = scan_wrap_s ? {SCAN_W{1'b0}} : scan_q + SCAN_W'(1'b1);
        digit_d = digit_q ^ scan_wrap_s;
    end

    // Output decode from the current registered state.
    always_comb begin
        led_d = 4'b0000;
        seg_d = SEG_BLANK;
        com_d = 2'b11;
        if (night_q) begin
            led_d = {2'b00, yel_q, 1'b0};
        end else begin
            led_d[3] = man_q;
            case (phase_q)
                PH_GREEN:  led_d[2:0] = 3'b100;
                PH_YELLOW: led_d[2:0] = 3'b010;
                PH_RED:    led_d[2:0] = 3'b001;
                default:   led_d[2:0] = 3'b100;
            endcase
            if (digit_q) begin
                com_d = 2'b01;
                seg_d = seg_code(bcd_s[7:4]);
            end else begin
                com_d = 2'b10;
                seg_d = seg_code(bcd_s[3:0]);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            phase_q <= PH_GREEN;
            cnt_q   <= GREEN_CNT;
            div_q   <= {DIV_W{1'b0}};
            yel_q   <= 1'b0;
            night_q <= 1'b0;
            man_q   <= 1'b0;
            scan_q  <= {SCAN_W{1'b0}};
            digit_q <= 1'b0;
            led_q   <= 4'b0100;
            seg_q   <= RESET_SEG;
            com_q   <= 2'b10;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            yel_q   <= yel_d;
            night_q <= Switch[0];
            man_q   <= Switch[1] & ~Switch[0];
            scan_q  <= scan_d;
            digit_q <= digit_d;
            led_q   <= led_d;
            seg_q   <= seg_d;
            com_q   <= com_d;
        end
    end

    assign LED = led_q;
    assign SEG = seg_q;
    assign COM = com_q;

endmodule

// File: tb/tb_three_color_light_top.sv
// Bench for three_color_light_top: directed scenarios plus random key/switch
// traffic, every cycle compared against a behavioural traffic-light model.
module tb_three_color_light_top;
    localparam int TICK_DIV = 10;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int GREEN_S  = 3;
    localparam int YELLOW_S = 2;
    localparam int RED_S    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key;
    logic [1:0] sw;
    logic [3:0] led;
    logic [7:0] seg;
    logic [1:0] com;

    int checks = 0;
    int errors = 0;

    three_color_light_top #(
        .CLK_HZ   (50_000_000),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE),
        .GREEN_S  (GREEN_S),
        .YELLOW_S (YELLOW_S),
        .RED_S    (RED_S)
    ) dut (
        .Sys_CLK (clk),
        .Sys_RST (rst),
        .Key     (key),
        .Switch  (sw),
        .LED     (led),
        .SEG     (seg),
        .COM     (com)
    );

    always #5 clk = ~clk;

    // Reference model: phase index 0/1/2 = green/yellow/red, plain integers.
    int m_phase, m_cnt, m_div, m_yel, m_night, m_man, m_scan, m_digit;
    int kh [2][16];
    int lvl [2];
    int rh [2][2];
    int dur [3] = '{GREEN_S, YELLOW_S, RED_S};
    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [3:0] e_led;
    logic [7:0] e_seg;
    logic [1:0] e_com;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = GREEN_S; m_div = 0; m_yel = 0;
        m_night = 0; m_man = 0; m_scan = 0; m_digit = 0;
        for (int i = 0; i < 2; i++) begin
            lvl[i] = 0; rh[i][0] = 0; rh[i][1] = 0;
            for (int j = 0; j < 16; j++) kh[i][j] = 0;
        end
    endtask

    task automatic model_outputs();
        if (m_night != 0) begin
            e_led = (m_yel != 0) ? 4'b0010 : 4'b0000;
            e_seg = 8'hFF;
            e_com = 2'b11;
        end else begin
            e_led = (m_man != 0) ? 4'b1000 : 4'b0000;
            if (m_phase == 0) e_led = e_led | 4'b0100;
            else if (m_phase == 1) e_led = e_led | 4'b0010;
            else e_led = e_led | 4'b0001;
            e_com = (m_digit != 0) ? 2'b01 : 2'b10;
            e_seg = segtab[(m_digit != 0) ? (m_cnt / 10) : (m_cnt % 10)];
        end
    endtask

    task automatic model_advance();
        m_phase = (m_phase + 1) % 3;
        m_cnt   = dur[m_phase];
    endtask

    // One rising edge of the system as described by the phase rules.
    task automatic model_edge();
        int press [2];
        int flip, tick, night_prev, ped_ok;
        if (rst) begin
            model_reset();
            model_outputs();
        end else begin
            model_outputs();
            for (int i = 0; i < 2; i++) begin
                press[i] = rh[i][1];
                flip = 1;
                for (int j = 1; j <= DEBOUNCE; j++) if (kh[i][j] == lvl[i]) flip = 0;
                rh[i][1] = rh[i][0];
                rh[i][0] = (flip != 0 && lvl[i] == 0) ? 1 : 0;
                if (flip != 0) lvl[i] = 1 - lvl[i];
                for (int j = 15; j > 0; j--) kh[i][j] = kh[i][j-1];
                kh[i][0] = int'(key[i]);
            end
            tick  = (m_div == TICK_DIV - 1) ? 1 : 0;
            m_div = (tick != 0) ? 0 : m_div + 1;
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0; m_digit = 1 - m_digit;
            end else begin
                m_scan++;
            end
            night_prev = m_night;
            m_night = int'(sw[0]);
            m_man   = (sw[1] && !sw[0]) ? 1 : 0;
            ped_ok  = (press[1] != 0 && m_phase == 0 && m_cnt > YELLOW_S) ? 1 : 0;
            if (sw[0]) begin
                m_phase = 0; m_cnt = GREEN_S;
                if (tick != 0) m_yel = 1 - m_yel;
            end else if (night_prev != 0) begin
                m_phase = 0; m_cnt = GREEN_S; m_div = 0; m_yel = 0;
            end else if (sw[1]) begin
                if (press[0] != 0) model_advance();
                else if (ped_ok != 0) m_cnt = YELLOW_S;
            end else begin
                if (ped_ok != 0) m_cnt = YELLOW_S;
                else if (tick != 0) begin
                    if (m_cnt > 1) m_cnt--;
                    else model_advance();
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [1:0] s, input logic [1:0] k);
        @(negedge clk);
        rst = r; sw = s; key = k;
        @(posedge clk);
        #1;
        model_edge();
        check_eq("led", {4'b0000, led}, {4'b0000, e_led});
        check_eq("seg", seg, e_seg);
        check_eq("com", {6'b000000, com}, {6'b000000, e_com});
    endtask

    task automatic run(input int n, input logic [1:0] s, input logic [1:0] k);
        for (int i = 0; i < n; i++) cycle(1'b0, s, k);
    endtask

    initial begin
        int hold [2];
        logic [1:0] kv;
        logic [1:0] sv;
        logic rv;
        rst = 1'b1; sw = 2'b00; key = 2'b00;
        model_reset();

        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b00, 2'b00);
        check_eq("reset_led", {4'b0000, led}, 8'h04);
        check_eq("reset_seg", seg, 8'hB0);
        check_eq("reset_com", {6'b000000, com}, 8'h02);

        run(30, 2'b00, 2'b00);
        check_eq("green_30", {4'b0000, led}, 8'h04);
        run(1, 2'b00, 2'b00);
        check_eq("yellow_31", {4'b0000, led}, 8'h02);
        run(90, 2'b00, 2'b00);

        run(40, 2'b01, 2'b00);
        run(2, 2'b00, 2'b00);
        check_eq("night_exit", {4'b0000, led}, 8'h04);
        run(10, 2'b00, 2'b00);

        run(10, 2'b10, 2'b01);
        run(30, 2'b10, 2'b00);
        run(5, 2'b10, 2'b00);

        cycle(1'b1, 2'b00, 2'b00);
        run(4, 2'b00, 2'b10);
        run(20, 2'b00, 2'b00);
        run(4, 2'b00, 2'b10);
        run(20, 2'b00, 2'b00);

        run(2, 2'b10, 2'b01);
        run(20, 2'b10, 2'b00);

        cycle(1'b1, 2'b00, 2'b00);
        run(55, 2'b00, 2'b00);
        check_eq("mid_red", {4'b0000, led}, 8'h01);
        cycle(1'b1, 2'b00, 2'b00);
        check_eq("rst_red_led", {4'b0000, led}, 8'h04);
        check_eq("rst_red_seg", seg, 8'hB0);
        check_eq("rst_red_com", {6'b000000, com}, 8'h02);

        hold[0] = 0; hold[1] = 0; kv = 2'b00; sv = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (hold[i] == 0) begin
                    kv[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 8);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 199) == 0) sv = 2'($urandom_range(0, 3));
            rv = ($urandom_range(0, 599) == 0);
            cycle(rv, sv, kv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
